spi_adc_rx: RTL and testbench

Parametrised multi-channel serial ADC receiver for AD7476-class converters (PmodAD1 and wider boards). It drives a shared chip-select and serial clock derived by clock-enable from the system clock, and shifts NCH data lines in parallel. It presents DATA_BITS-wide samples per channel with a one-cycle valid strobe. It sits between the Pmod pins and the user datapath; no internal derived clocks.

---
 rtl/spi_adc_pkg.sv | 20 ++
 rtl/spi_adc_sclk_gen.sv | 38 +++
 rtl/spi_adc_rx.sv | 134 +++++++++++++
 tb/tb_spi_adc_rx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_adc_pkg.sv
// Shared types and counter-width helpers for the spi_adc_rx serial ADC receiver.
package spi_adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        QUIET = 2'd2
    } state_t;

    // Width of a counter that holds 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_CLK_DIV    = 2;
    localparam int unsigned DEF_FRAME_BITS = 16;
    localparam int unsigned DEF_DIV_W      = cnt_w(DEF_CLK_DIV);
    localparam int unsigned DEF_BIT_W      = $clog2(DEF_FRAME_BITS + 1);

endpackage

// File: rtl/spi_adc_sclk_gen.sv
// Serial clock generator: divides clk by 2*CLK_DIV while enabled, parks sclk high otherwise.
module spi_adc_sclk_gen
    import spi_adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_c
);

    localparam int unsigned DIV_W = cnt_w(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap_c;

    assign wrap_c = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    // Asserted on the clk edge that drives sclk from low to high.
    assign rise_c = wrap_c && !sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
        end else if (!en) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
        end else if (wrap_c) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_adc_rx.sv
// Multi-channel AD7476-class serial ADC receiver with shared ncs/sclk.
// Optional leading-zero frame check enabled by defining SPI_ADC_RX_FRAME_CHECK_EN.
module spi_adc_rx
    import spi_adc_pkg::*;
#(
    parameter int unsigned NCH        = 2,
    parameter int unsigned FRAME_BITS = 16,
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned QUIET_CYC  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NCH-1:0]           sdata,
    output logic                     sclk,
    output logic                     ncs,
    output logic [NCH*DATA_BITS-1:0] data,
    output logic                     valid,
    output logic                     done,
    output logic                     busy,
    output logic [NCH-1:0]           frame_err
);

    localparam int unsigned BIT_W = $clog2(FRAME_BITS + 1);
    localparam int unsigned Q_W   = cnt_w(QUIET_CYC);
    // Only bits that are published or checked are stored; the newest bit comes straight from sdata.
`ifdef SPI_ADC_RX_FRAME_CHECK_EN
    localparam int unsigned SR_W  = FRAME_BITS - 1;
`else
    localparam int unsigned SR_W  = DATA_BITS - 1;
`endif

    state_t           state, state_next;
    logic [BIT_W-1:0] bit_cnt;
    logic [Q_W-1:0]   q_cnt;
    logic             rise_c;
    logic             last_rise_c;
    logic             quiet_end_c;
    logic             conv_en_c;
    logic [SR_W-1:0]  sr [NCH];

    assign conv_en_c   = (state == CONV);
    assign last_rise_c = rise_c && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign quiet_end_c = (q_cnt == Q_W'(QUIET_CYC - 1));

    spi_adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (conv_en_c),
        .sclk   (sclk),
        .rise_c (rise_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)       state_next = CONV;
            CONV:    if (last_rise_c) state_next = QUIET;
            QUIET:   if (quiet_end_c) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Bit counter runs only in CONV, quiet counter only in QUIET.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            q_cnt   <= '0;
        end else begin
            if (state != CONV) bit_cnt <= '0;
            else if (rise_c)   bit_cnt <= bit_cnt + 1'b1;
            if (state != QUIET) q_cnt <= '0;
            else                q_cnt <= q_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) sr[i] <= '0;
        end else if (state == IDLE && start) begin
            for (int i = 0; i < NCH; i++) sr[i] <= '0;
        end else if (rise_c) begin
            for (int i = 0; i < NCH; i++) sr[i] <= {sr[i][SR_W-2:0], sdata[i]};
        end
    end

    // Outputs follow the next state so ncs/done/busy change on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            valid <= 1'b0;
            data  <= '0;
        end else begin
            ncs   <= (state_next != CONV);
            done  <= (state_next == IDLE);
            busy  <= (state_next != IDLE);
            valid <= last_rise_c;
            if (last_rise_c) begin
                for (int i = 0; i < NCH; i++)
                    data[i*DATA_BITS +: DATA_BITS] <= {sr[i][DATA_BITS-2:0], sdata[i]};
            end
        end
    end

`ifdef SPI_ADC_RX_FRAME_CHECK_EN
    generate
        if (FRAME_BITS > DATA_BITS) begin : g_frame_chk
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    frame_err <= '0;
                end else if (last_rise_c) begin
                    for (int i = 0; i < NCH; i++)
                        frame_err[i] <= |sr[i][SR_W-1:DATA_BITS-1];
                end
            end
        end else begin : g_no_lead
            assign frame_err = '0;
        end
    endgenerate
`else
    assign frame_err = '0;
`endif

endmodule

// File: tb/tb_spi_adc_rx.sv
// Bench for spi_adc_rx: default 2-channel instance plus a 4-channel CLK_DIV=1 instance.
module tb_spi_adc_rx;

`ifdef SPI_ADC_RX_FRAME_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int FB_A = 16;
    localparam int FB_B = 14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [1:0]  sdata_a = '0;
    logic [3:0]  sdata_b = '0;
    logic        sclk_a, ncs_a, valid_a, done_a, busy_a;
    logic        sclk_b, ncs_b, valid_b, done_b, busy_b;
    logic [23:0] data_a;
    logic [47:0] data_b;
    logic [1:0]  frame_err_a;
    logic [3:0]  frame_err_b;

    always #5 clk = ~clk;

    spi_adc_rx u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .sdata(sdata_a),
        .sclk(sclk_a), .ncs(ncs_a), .data(data_a), .valid(valid_a),
        .done(done_a), .busy(busy_a), .frame_err(frame_err_a)
    );

    spi_adc_rx #(
        .NCH(4), .FRAME_BITS(FB_B), .DATA_BITS(12), .CLK_DIV(1), .QUIET_CYC(4)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .sdata(sdata_b),
        .sclk(sclk_b), .ncs(ncs_b), .data(data_b), .valid(valid_b),
        .done(done_b), .busy(busy_b), .frame_err(frame_err_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC models: MSB first, next bit presented after each sclk fall, index rearmed while ncs high.
    logic [15:0] fa [2];
    int          ia = FB_A;
    always @(negedge sclk_a or posedge ncs_a) begin
        if (ncs_a) ia = FB_A;
        else if (ia > 0) begin
            ia--;
            for (int c = 0; c < 2; c++) sdata_a[c] = fa[c][ia];
        end
    end

    logic [55:0] fb_w;
    int          ib = FB_B;
    always @(negedge sclk_b or posedge ncs_b) begin
        if (ncs_b) ib = FB_B;
        else if (ib > 0) begin
            ib--;
            for (int c = 0; c < 4; c++) sdata_b[c] = fb_w[c*FB_B + ib];
        end
    end

    typedef struct {
        logic [23:0] d;
        logic [1:0]  e;
    } exp_t;

    typedef struct {
        logic [15:0] f0;
        logic [15:0] f1;
        logic [23:0] d;
        logic [1:0]  e;
    } vec_t;

    exp_t exp_q[$];
    int   vcyc[$];
    exp_t e_mon;

    // Scoreboard consumer for instance A.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_a === 1'b1) begin
            vcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("valid_unexpected", 64'(valid_a), 64'd0);
            end else begin
                e_mon = exp_q.pop_front();
                chk("data_a", 64'(data_a), 64'(e_mon.d));
                chk("frame_err_a", 64'(frame_err_a), 64'(e_mon.e));
            end
        end
    end

    task automatic push_exp(input logic [23:0] d, input logic [1:0] e);
        exp_t x;
        x.d = d;
        x.e = CHK_EN ? e : 2'b00;
        exp_q.push_back(x);
    endtask

    task automatic wait_done_a(input string name);
        for (int k = 0; k < 300 && done_a !== 1'b1; k++) @(negedge clk);
        chk(name, 64'(done_a), 64'd1);
    endtask

    task automatic run_a(input vec_t v, output int t0);
        @(negedge clk);
        fa[0] = v.f0;
        fa[1] = v.f1;
        start_a = 1'b1;
        t0 = cyc;
        push_exp(v.d, v.e);
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("done_timeout");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vt [6];
    int   t0, ncs_low, rises, seen_low, run, hr, vb_cnt;
    logic prev_sclk;
    logic [55:0] bfr [2];
    logic [47:0] bd  [2];
    logic [3:0]  be  [2];

    initial begin
        vt[0] = '{16'h0ABC, 16'h0123, 24'h123ABC, 2'b00};
        vt[1] = '{16'h0FFF, 16'h0000, 24'h000FFF, 2'b00};
        vt[2] = '{16'h0555, 16'h4AAA, 24'hAAA555, 2'b10};
        vt[3] = '{16'hF800, 16'h0001, 24'h001800, 2'b01};
        vt[4] = '{16'h0000, 16'h0000, 24'h000000, 2'b00};
        vt[5] = '{16'h8001, 16'h8FFF, 24'hFFF001, 2'b11};
        bfr[0] = {14'h2AAA, 14'h1555, 14'h0FED, 14'h0123};
        bd[0]  = 48'hAAA555FED123;
        be[0]  = 4'b1100;
        bfr[1] = {14'h0001, 14'h0800, 14'h0000, 14'h3FFF};
        bd[1]  = 48'h001800000FFF;
        be[1]  = 4'b0001;
        fa[0] = '0; fa[1] = '0; fb_w = '0;

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ncs", 64'(ncs_a), 64'd1);
        chk("rst_sclk", 64'(sclk_a), 64'd1);
        chk("rst_done", 64'(done_a), 64'd1);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_data", 64'(data_a), 64'd0);
        chk("rst_err", 64'(frame_err_a), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame: ncs low length, sclk rising edges, start-to-valid latency.
        vcyc.delete();
        @(negedge clk);
        fa[0] = vt[0].f0; fa[1] = vt[0].f1;
        start_a = 1'b1; t0 = cyc;
        push_exp(vt[0].d, vt[0].e);
        ncs_low = 0; rises = 0; prev_sclk = sclk_a;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) start_a = 1'b0;
            if (!ncs_a) ncs_low++;
            if (sclk_a && !prev_sclk) rises++;
            prev_sclk = sclk_a;
            if (k == 40) begin
                chk("mid_busy", 64'(busy_a), 64'd1);
                chk("mid_done", 64'(done_a), 64'd0);
            end
        end
        chk("ncs_low_cycles", 64'(ncs_low), 64'd64);
        chk("sclk_rises", 64'(rises), 64'd16);
        chk("latency", 64'(vcyc.size() > 0 ? vcyc[0] - t0 : 0), 64'd65);
        chk("done_after", 64'(done_a), 64'd1);

        for (int i = 0; i < 6; i++) run_a(vt[i], t0);

        // start held high for three frames.
        vcyc.delete();
        @(negedge clk);
        fa[0] = vt[2].f0; fa[1] = vt[2].f1;
        start_a = 1'b1;
        for (int i = 0; i < 3; i++) push_exp(vt[2].d, vt[2].e);
        seen_low = 0; run = 0; hr = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 150) start_a = 1'b0;
            if (!ncs_a) begin
                if (seen_low != 0 && run > 0 && hr < 0) hr = run;
                seen_low = 1;
                run = 0;
            end else if (seen_low != 0) begin
                run++;
            end
            if (k > 150 && done_a) break;
        end
        chk("b2b_valids", 64'(vcyc.size()), 64'd3);
        chk("b2b_gap1", 64'(vcyc.size() == 3 ? vcyc[1] - vcyc[0] : 0), 64'd69);
        chk("b2b_gap2", 64'(vcyc.size() == 3 ? vcyc[2] - vcyc[1] : 0), 64'd69);
        chk("b2b_ncs_high", 64'(hr), 64'd5);

        // start toggled during CONV and QUIET.
        vcyc.delete();
        @(negedge clk);
        fa[0] = vt[1].f0; fa[1] = vt[1].f1;
        start_a = 1'b1; t0 = cyc;
        push_exp(vt[1].d, vt[1].e);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start_a = (k <= 66) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        chk("toggle_valids", 64'(vcyc.size()), 64'd1);
        chk("toggle_latency", 64'(vcyc.size() > 0 ? vcyc[0] - t0 : 0), 64'd65);

        // Reset at cycle 30 of a frame.
        vcyc.delete();
        @(negedge clk);
        fa[0] = vt[3].f0; fa[1] = vt[3].f1;
        start_a = 1'b1;
        push_exp(vt[3].d, vt[3].e);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_ncs", 64'(ncs_a), 64'd1);
        chk("arst_sclk", 64'(sclk_a), 64'd1);
        chk("arst_data", 64'(data_a), 64'd0);
        chk("arst_valid", 64'(valid_a), 64'd0);
        chk("arst_done", 64'(done_a), 64'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("arst_no_valid", 64'(vcyc.size()), 64'd0);
        run_a(vt[5], t0);
        chk("arst_fresh_valid", 64'(vcyc.size()), 64'd1);

        // Four-channel, 14-bit frame, CLK_DIV=1 instance.
        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            fb_w = bfr[f];
            start_b = 1'b1;
            ncs_low = 0; rises = 0; vb_cnt = 0; prev_sclk = sclk_b;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                start_b = 1'b0;
                if (!ncs_b) ncs_low++;
                if (sclk_b && !prev_sclk) rises++;
                prev_sclk = sclk_b;
                if (valid_b) vb_cnt++;
                if (k == 10) chk("b_busy", 64'(busy_b), 64'd1);
            end
            chk("b_ncs_low", 64'(ncs_low), 64'd28);
            chk("b_sclk_rises", 64'(rises), 64'd14);
            chk("b_valids", 64'(vb_cnt), 64'd1);
            chk("b_done", 64'(done_b), 64'd1);
            chk("b_data", 64'(data_b), 64'(bd[f]));
            chk("b_frame_err", 64'(frame_err_b), CHK_EN ? 64'(be[f]) : 64'd0);
        end

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
